// File: rtl/sram_data_controller.sv
// Sequences one 32-bit MEM-stage load/store into two 16-bit asynchronous SRAM
// accesses (low half first), holding ready low so the pipeline freezes meanwhile.
module sram_data_controller #(
   parameter int unsigned DATA_BASE     = 1024,
   parameter int unsigned ACCESS_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        ready,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   inout  wire  [15:0] SRAM_DQ
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        is_wr_q, is_wr_d;
   logic [16:0] word_q, word_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [17:0] addr_q, addr_d;
   logic        we_n_q, we_n_d;
   logic        oe_q, oe_d;
   logic [15:0] dout_q, dout_d;
   logic [16:0] word_s;
   logic        ready_s;

   // Byte offset into data memory, wrapped to the 17-bit word space of the SRAM.
   assign word_s = 17'((address - 32'(DATA_BASE)) >> 2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         is_wr_q <= 1'b0;
         word_q  <= 17'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         addr_q  <= 18'd0;
         we_n_q  <= 1'b1;
         oe_q    <= 1'b0;
         dout_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         is_wr_q <= is_wr_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         we_n_q  <= we_n_d;
         oe_q    <= oe_d;
         dout_q  <= dout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      is_wr_d = is_wr_q;
      word_d  = word_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ready_s = 1'b0;
      addr_d  = 18'd0;
      we_n_d  = 1'b1;
      oe_d    = 1'b0;
      dout_d  = 16'd0;

      case (state_q)
         IDLE: begin
            ready_s = ~(rd_en | wr_en);
            cnt_d   = 4'd0;
            if (wr_en | rd_en) begin
               is_wr_d = wr_en;
               word_d  = word_s;
               wdata_d = writeData;
               state_d = LOW;
            end else begin
               state_d = IDLE;
            end
         end
         LOW: begin
            if (cnt_q == CNT_LAST) begin
               if (!is_wr_q) begin
                  rdata_d[15:0] = SRAM_DQ;
               end else begin
                  rdata_d = rdata_q;
               end
               cnt_d   = 4'd0;
               state_d = HIGH;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HIGH: begin
            if (cnt_q == CNT_LAST) begin
               if (!is_wr_q) begin
                  rdata_d[31:16] = SRAM_DQ;
               end else begin
                  rdata_d = rdata_q;
               end
               cnt_d   = 4'd0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            ready_s = 1'b1;
            cnt_d   = 4'd0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = 4'd0;
            state_d = IDLE;
         end
      endcase

      // Bus controls are decoded from the next state so they register cleanly on the edge.
      case (state_d)
         LOW: begin
            addr_d = {word_d, 1'b0};
            we_n_d = ~is_wr_d;
            oe_d   = is_wr_d;
            dout_d = wdata_d[15:0];
         end
         HIGH: begin
            addr_d = {word_d, 1'b1};
            we_n_d = ~is_wr_d;
            oe_d   = is_wr_d;
            dout_d = wdata_d[31:16];
         end
         default: begin
            addr_d = 18'd0;
            we_n_d = 1'b1;
            oe_d   = 1'b0;
            dout_d = 16'd0;
         end
      endcase
   end

   assign ready     = ready_s;
   assign readData  = rdata_q;
   assign SRAM_ADDR = addr_q;
   assign SRAM_WE_N = we_n_q;
   assign SRAM_DQ   = oe_q ? dout_q : 16'hzzzz;

endmodule
